payload_nfa_engine: RTL

- Parametrised successor to the fixed per-rule payload engines: one generic shift/NFA chain matching a linear PCRE fragment.
- Each state is tied to one character-class hit line. Self-loops (x*, x+, [^>]*) and single-state skips (optional atoms such as \s*) are set by parameters, not by generated per-rule modules.
- Sits after the shared character-class decoder in the payload engine. Reports a per-packet result (match flag, first-match offset, match count) to the rule collector over a valid/ready handshake.

---
 rtl/payload_nfa_pkg.sv | 36 +++
 rtl/payload_nfa_cell.sv | 33 +++
 rtl/payload_nfa_engine.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/payload_nfa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | payload_nfa_pkg: shared types and helpers for the payload NFA engine.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package payload_nfa_pkg;

   typedef enum logic [0:0] {
      SCAN   = 1'b0,
      REPORT = 1'b1
   } fsm_t;

   localparam int unsigned c_SEL_MAX_W = 4096;

   function automatic int unsigned cidx_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned cls_field(input logic [c_SEL_MAX_W-1:0] sel,
                                             input int unsigned i,
                                             input int unsigned w);
      logic [c_SEL_MAX_W-1:0] v;
      logic [31:0]            mask;
      mask = (32'd1 << w) - 32'd1;
      v    = sel >> (i * w);
      return int'(v[31:0] & mask);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] lim;
      lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= lim) ? lim : v + 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/payload_nfa_cell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | payload_nfa_cell: one NFA state flop fed by a class hit and up to three    |
// | predecessor terms. Revision: 1.0                                           |
// +----------------------------------------------------------------------------+
module payload_nfa_cell (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_clr,
   input  logic       i_hit,
   input  logic [2:0] i_pred,
   output logic       o_next,
   output logic       o_state
);

   logic r_state;

   assign o_next  = i_hit & (|i_pred);
   assign o_state = r_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= 1'b0;
      end else if (i_clr) begin
         r_state <= 1'b0;
      end else if (i_en) begin
         r_state <= o_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/payload_nfa_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | payload_nfa_engine: parametrised shift/NFA chain for a linear PCRE         |
// | fragment with per-packet result handshake. Optional debug ports are        |
// | enabled by PAYLOAD_NFA_DBG_EN. Revision: 1.0                               |
// +----------------------------------------------------------------------------+
module payload_nfa_engine
   import payload_nfa_pkg::*;
#(
   parameter int unsigned NUM_CLASSES = 128,
   parameter int unsigned NUM_STATES  = 19,
   parameter logic [NUM_STATES*cidx_w(NUM_CLASSES)-1:0] CLASS_SEL = '0,
   parameter logic [NUM_STATES-1:0] SELF_LOOP = '0,
   parameter logic [NUM_STATES-1:0] SKIP_PREV = '0,
   parameter bit          ANCHORED    = 1'b0,
   parameter int unsigned OFS_W       = 16,
   parameter int unsigned CNT_W       = 8
)(
   input  logic                   clk,
   input  logic                   sod,
   input  logic                   en,
   input  logic [NUM_CLASSES-1:0] cls_hit,
   input  logic                   eod,
   output logic                   in_ready,
   output logic                   result_valid,
   input  logic                   result_ready,
   output logic                   out,
   output logic [OFS_W-1:0]       match_ofs,
   output logic [CNT_W-1:0]       match_cnt
`ifdef PAYLOAD_NFA_DBG_EN
   ,
   output logic [NUM_STATES-1:0]  dbg_state,
   output logic [OFS_W-1:0]       dbg_bytes
`endif
);

   localparam int unsigned c_CIDX_W = cidx_w(NUM_CLASSES);

   fsm_t                  r_fsm;
   fsm_t                  w_fsm_nxt;
   logic [NUM_STATES-1:0] w_state;
   logic [NUM_STATES-1:0] w_next;
   logic                  r_first;
   logic                  r_out;
   logic [OFS_W-1:0]      r_byte_cnt;
   logic [OFS_W-1:0]      r_match_ofs;
   logic [CNT_W-1:0]      r_match_cnt;
   logic                  w_step;
   logic                  w_clr;
   logic                  w_hit;
   logic                  w_unused_hits;

   assign w_step        = en & (r_fsm == SCAN);
   assign w_clr         = (r_fsm == REPORT) & result_ready;
   assign w_hit         = w_next[NUM_STATES-1];
   assign w_unused_hits = ^cls_hit;

   assign in_ready     = (r_fsm == SCAN);
   assign result_valid = (r_fsm == REPORT);
   assign out          = r_out;
   assign match_ofs    = r_match_ofs;
   assign match_cnt    = r_match_cnt;

   generate
      for (genvar i = 0; i < NUM_STATES; i++) begin : g_state
         localparam int unsigned c_IDX = cls_field(c_SEL_MAX_W'(CLASS_SEL), i, c_CIDX_W);
         localparam int unsigned c_IDX_SAFE = (c_IDX < NUM_CLASSES) ? c_IDX : 0;
         logic [2:0] w_pred;

         if (c_IDX >= NUM_CLASSES) begin : g_bad_sel
            $error("payload_nfa_engine: CLASS_SEL field %0d out of range", i);
         end

         // pred bits: {skip from i-2, self loop, chain from i-1 / start}
         if (i == 0) begin : g_head
            assign w_pred = {1'b0, SELF_LOOP[i] & w_state[i], ANCHORED ? r_first : 1'b1};
         end else if (i == 1) begin : g_second
            assign w_pred = {1'b0, SELF_LOOP[i] & w_state[i], w_state[i-1]};
         end else begin : g_body
            assign w_pred = {SKIP_PREV[i] & w_state[i-2], SELF_LOOP[i] & w_state[i], w_state[i-1]};
         end

         payload_nfa_cell u_cell (
            .clk     (clk),
            .rst     (sod),
            .i_en    (w_step),
            .i_clr   (w_clr),
            .i_hit   (cls_hit[c_IDX_SAFE]),
            .i_pred  (w_pred),
            .o_next  (w_next[i]),
            .o_state (w_state[i])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge sod) begin
      if (sod) begin
         r_fsm <= SCAN;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      case (r_fsm)
         SCAN:    if (w_step && eod) w_fsm_nxt = REPORT;
         REPORT:  if (result_ready)  w_fsm_nxt = SCAN;
         default: w_fsm_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk or posedge sod) begin
      if (sod) begin
         r_first     <= 1'b1;
         r_out       <= 1'b0;
         r_byte_cnt  <= '0;
         r_match_ofs <= '0;
         r_match_cnt <= '0;
      end else if (w_clr) begin
         r_first     <= 1'b1;
         r_out       <= 1'b0;
         r_byte_cnt  <= '0;
         r_match_ofs <= '0;
         r_match_cnt <= '0;
      end else if (w_step) begin
         r_first    <= 1'b0;
         r_byte_cnt <= OFS_W'(sat_inc(32'(r_byte_cnt), OFS_W));
         if (w_hit) begin
            r_out       <= 1'b1;
            r_match_cnt <= CNT_W'(sat_inc(32'(r_match_cnt), CNT_W));
            // offset is the pre-increment count, already saturated
            if (!r_out) begin
               r_match_ofs <= r_byte_cnt;
            end
         end
      end
   end

`ifdef PAYLOAD_NFA_DBG_EN
   assign dbg_state = w_state;
   assign dbg_bytes = r_byte_cnt;
`else
   // state vector and byte counter remain internal
`endif

endmodule
`default_nettype wire
